// File: rtl/latch_bank_pkg.sv
// Shared definitions for the latch bank: default geometry, the summing FSM
// state encoding and the width rule for the channel sum.
package latch_bank_pkg;

  localparam int unsigned DefaultDataW = 4;
  localparam int unsigned DefaultNumCh = 2;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StDone
  } sum_state_e;

  // Enough headroom that adding NUM_CH full-scale channels never overflows.
  function automatic int unsigned sum_width(input int unsigned data_w,
                                            input int unsigned num_ch);
    return data_w + $clog2(num_ch);
  endfunction

endpackage

// File: rtl/latch_bank_save_sync.sv
// One save strobe: two-flop synchroniser followed by a falling-edge detector.
// All flops come out of reset at 1 (button released), so a strobe that is
// high at reset release never looks like a press.
module save_sync
  import latch_bank_pkg::*;
(
  input  logic clk_i,
  input  logic reset_i,
  input  logic save_n_i,
  output logic fall_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Synchronise the raw strobe and keep a one-cycle-old copy for edge detection.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= save_n_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // High for exactly one cycle per high-to-low transition, however long the press.
  assign fall_o = prev_q & ~sync2_q;

endmodule

// File: rtl/latch_bank.sv
// Bank of NUM_CH data latches, each loaded from a shared bus by its own
// asynchronous active-low save strobe. Optional summing engine enabled by
// defining LATCH_BANK_SUM_EN; without it sum, sum_valid and busy read 0.
module latch_bank
  import latch_bank_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned NUM_CH = DefaultNumCh,
  localparam int unsigned SUM_W = sum_width(DATA_W, NUM_CH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        save_n,
  input  logic [DATA_W-1:0]        data_in,
  output logic [NUM_CH*DATA_W-1:0] q,
  output logic [SUM_W-1:0]         sum,
  output logic                     sum_valid,
  output logic                     busy
);

  logic [NUM_CH-1:0] fall;
  logic              capture;
  logic [DATA_W-1:0] q_q [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : gen_ch
    save_sync u_save_sync (
      .clk_i    (clk),
      .reset_i  (reset),
      .save_n_i (save_n[g]),
      .fall_o   (fall[g])
    );

    assign q[g*DATA_W +: DATA_W] = q_q[g];
  end

  assign capture = |fall;

  // Load every channel whose strobe fell this cycle; hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        q_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (fall[i]) begin
          q_q[i] <= data_in;
        end
      end
    end
  end

`ifdef LATCH_BANK_SUM_EN

  localparam int unsigned IdxW = $clog2(NUM_CH);

  sum_state_e        state_q, state_d;
  logic [SUM_W-1:0]  acc_q, acc_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              pending_q, pending_d;
  logic              valid_q, valid_d;
  logic [SUM_W-1:0]  chan_val;

  assign chan_val = SUM_W'(q_q[idx_q]);

  // Sequential pass over the channels; captures during a pass are remembered
  // and trigger one full re-run so the final sum reflects the latest q.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    sum_d     = sum_q;
    valid_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (capture) begin
          state_d = StAccum;
          acc_d   = '0;
          idx_d   = '0;
        end
      end
      StAccum: begin
        acc_d = acc_q + chan_val;
        idx_d = idx_q + 1'b1;
        if (capture) begin
          pending_d = 1'b1;
        end
        if (idx_q == IdxW'(NUM_CH - 1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        sum_d   = acc_q;
        valid_d = 1'b1;
        if (pending_q || capture) begin
          state_d   = StAccum;
          acc_d     = '0;
          idx_d     = '0;
          pending_d = 1'b0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM and datapath registers; reset discards any pass in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      idx_q     <= '0;
      pending_q <= 1'b0;
      sum_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      sum_q     <= sum_d;
      valid_q   <= valid_d;
    end
  end

  assign sum       = sum_q;
  assign sum_valid = valid_q;
  assign busy      = (state_q != StIdle);

`else

  assign sum       = '0;
  assign sum_valid = 1'b0;
  assign busy      = 1'b0;

`endif

endmodule

// File: tb/tb_latch_bank.sv
// Bench for latch_bank: directed scenarios plus randomized captures checked
// against a per-channel array model and a plain arithmetic channel total.
module tb_latch_bank;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned NUM_CH = 2;
  localparam int unsigned SUM_W  = DATA_W + $clog2(NUM_CH);
`ifdef LATCH_BANK_SUM_EN
  localparam bit SumEn = 1'b1;
`else
  localparam bit SumEn = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_CH-1:0]        save_n;
  logic [DATA_W-1:0]        data_in;
  logic [NUM_CH*DATA_W-1:0] q;
  logic [SUM_W-1:0]         sum;
  logic                     sum_valid;
  logic                     busy;

  int vectors = 0;
  int errors  = 0;

  logic [DATA_W-1:0] model_q [NUM_CH];

  latch_bank #(
    .DATA_W (DATA_W),
    .NUM_CH (NUM_CH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .save_n    (save_n),
    .data_in   (data_in),
    .q         (q),
    .sum       (sum),
    .sum_valid (sum_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NUM_CH*DATA_W-1:0] model_vec();
    logic [NUM_CH*DATA_W-1:0] v;
    for (int i = 0; i < NUM_CH; i++) v[i*DATA_W +: DATA_W] = model_q[i];
    return v;
  endfunction

  function automatic logic [SUM_W-1:0] model_sum();
    int unsigned t = 0;
    for (int i = 0; i < NUM_CH; i++) t += model_q[i];
    return SumEn ? SUM_W'(t) : '0;
  endfunction

  // Press the masked buttons with data d; returns just after the load edge
  // (e3) with the buttons still held low.
  task automatic capture(input logic [NUM_CH-1:0] mask, input logic [DATA_W-1:0] d,
                         input string tag);
    data_in = d;
    save_n  = ~mask;
    tick();  // e1
    tick();  // e2
    vectors++;
    if (q !== model_vec()) begin
      errors++;
      $display("FAIL %s_early_load: q got %h want %h", tag, q, model_vec());
    end
    tick();  // e3
    for (int i = 0; i < NUM_CH; i++) if (mask[i]) model_q[i] = d;
    vectors++;
    if (q !== model_vec()) begin
      errors++;
      $display("FAIL %s_load: q got %h want %h", tag, q, model_vec());
    end
  endtask

  // Called right after e3: pulse must appear after e3+NUM_CH+1 only.
  task automatic wait_sum(input string tag);
    logic exp_v;
    logic exp_b;
    for (int k = 1; k <= NUM_CH + 2; k++) begin
      tick();
      exp_v = SumEn && (k == NUM_CH + 1);
      exp_b = SumEn && (k <= NUM_CH);
      vectors++;
      if (sum_valid !== exp_v) begin
        errors++;
        $display("FAIL %s_valid_k%0d: got %b want %b", tag, k, sum_valid, exp_v);
      end
      vectors++;
      if (busy !== exp_b) begin
        errors++;
        $display("FAIL %s_busy_k%0d: got %b want %b", tag, k, busy, exp_b);
      end
      if (k == NUM_CH + 1) begin
        vectors++;
        if (sum !== model_sum()) begin
          errors++;
          $display("FAIL %s_sum: got %0d want %0d", tag, sum, model_sum());
        end
      end
    end
  endtask

  task automatic check_idle_zero(input string tag);
    vectors++;
    if (q !== '0 || sum !== '0 || sum_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: q=%h sum=%0d valid=%b busy=%b want all 0", tag, q, sum,
               sum_valid, busy);
    end
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    save_n  = '1;
    data_in = '0;
    for (int i = 0; i < NUM_CH; i++) model_q[i] = '0;
    repeat (3) tick();
    check_idle_zero("reset_state");
    reset = 1'b0;
    repeat (6) tick();
    check_idle_zero("reset_release");
  endtask

  task automatic test_single(input logic [NUM_CH-1:0] mask, input logic [DATA_W-1:0] d,
                             input string tag);
    capture(mask, d, tag);
    save_n = '1;
    wait_sum(tag);
  endtask

  // Second channel captured while the first pass is still accumulating.
  task automatic test_overlap();
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [SUM_W-1:0]  last;
    int pulses = 0;
    int busy_cycles = 0;
    a = DATA_W'($urandom);
    b = DATA_W'($urandom);
    last = '0;
    data_in   = a;
    save_n    = '1;
    save_n[0] = 1'b0;
    tick();  // e1 for ch0
    save_n[1] = 1'b0;
    tick();  // e2
    tick();  // e3: ch0 loads a, pass starts
    model_q[0] = a;
    data_in = b;
    vectors++;
    if (q !== model_vec()) begin
      errors++;
      $display("FAIL overlap_load0: q got %h want %h", q, model_vec());
    end
    if (busy === 1'b1) busy_cycles++;
    tick();  // e4: ch1 loads b mid-pass
    model_q[1] = b;
    save_n = '1;
    vectors++;
    if (q !== model_vec()) begin
      errors++;
      $display("FAIL overlap_load1: q got %h want %h", q, model_vec());
    end
    if (busy === 1'b1) busy_cycles++;
    if (sum_valid === 1'b1) pulses++;
    for (int k = 0; k < 3 * (NUM_CH + 1) + 4; k++) begin
      tick();
      if (busy === 1'b1) busy_cycles++;
      if (sum_valid === 1'b1) begin
        pulses++;
        last = sum;
      end
    end
    vectors++;
    if (pulses != (SumEn ? 2 : 0)) begin
      errors++;
      $display("FAIL overlap_pulses: got %0d want %0d", pulses, SumEn ? 2 : 0);
    end
    vectors++;
    if (busy_cycles != (SumEn ? 2 * (NUM_CH + 1) : 0)) begin
      errors++;
      $display("FAIL overlap_busy_cycles: got %0d want %0d", busy_cycles,
               SumEn ? 2 * (NUM_CH + 1) : 0);
    end
    vectors++;
    if (last !== model_sum()) begin
      errors++;
      $display("FAIL overlap_final_sum: got %0d want %0d", last, model_sum());
    end
  endtask

  // Long press yields one capture; release yields none.
  task automatic test_hold_low();
    int pulses = 0;
    int busy_cycles = 0;
    capture(NUM_CH'(1), DATA_W'($urandom), "hold");
    wait_sum("hold");
    for (int k = 0; k < 100; k++) begin
      data_in = DATA_W'($urandom);
      tick();
      if (sum_valid === 1'b1) pulses++;
      if (busy === 1'b1) busy_cycles++;
    end
    vectors++;
    if (q !== model_vec()) begin
      errors++;
      $display("FAIL hold_q: got %h want %h", q, model_vec());
    end
    save_n = '1;
    for (int k = 0; k < 10; k++) begin
      data_in = DATA_W'($urandom);
      tick();
      if (sum_valid === 1'b1) pulses++;
      if (busy === 1'b1) busy_cycles++;
    end
    vectors++;
    if (q !== model_vec()) begin
      errors++;
      $display("FAIL release_q: got %h want %h", q, model_vec());
    end
    vectors++;
    if (pulses != 0 || busy_cycles != 0) begin
      errors++;
      $display("FAIL hold_extra_pass: pulses %0d busy %0d want 0 0", pulses, busy_cycles);
    end
  endtask

  task automatic test_random();
    logic [NUM_CH-1:0] m;
    for (int n = 0; n < 8; n++) begin
      m = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
      test_single(m, DATA_W'($urandom), $sformatf("rand%0d", n));
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    int busy_cycles = 0;
    capture(NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1)), DATA_W'($urandom), "rmid");
    save_n = '1;
    tick();  // e4: pass in progress
    reset = 1'b1;
    tick();
    for (int i = 0; i < NUM_CH; i++) model_q[i] = '0;
    check_idle_zero("reset_mid");
    reset = 1'b0;
    for (int k = 0; k < NUM_CH + 4; k++) begin
      tick();
      if (sum_valid === 1'b1) pulses++;
      if (busy === 1'b1) busy_cycles++;
    end
    vectors++;
    if (pulses != 0 || busy_cycles != 0) begin
      errors++;
      $display("FAIL reset_mid_after: pulses %0d busy %0d want 0 0", pulses, busy_cycles);
    end
    check_idle_zero("reset_mid_settled");
  endtask

  initial begin
    test_reset();
    test_single(NUM_CH'(1), DATA_W'(5), "first");
    test_single(NUM_CH'(2), DATA_W'(15), "second");
    test_single('1, DATA_W'(9), "both");
    repeat (3) tick();
    test_overlap();
    repeat (3) tick();
    test_hold_low();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
